alu_rr_scheduler: RTL and testbench
===================================

# alu_rr_scheduler

Round-robin scheduler that shares the single 8-bit ALU between NUM_REQ independent requesters. It accepts one operation at a time from a valid/ready request port and drives the ALU's load/opcode/operand inputs. It then captures the ALU result and returns it on a tagged response port. It sits directly in front of the ALU and is the only driver of the ALU's load_en.

## Interface

- NUM_REQ, 4, number of requesters (2..8)
- ID_W, $clog2(NUM_REQ), width of requester tag
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low
- req_valid  input  NUM_REQ  per-requester request valid
- req_ready  output  NUM_REQ  per-requester accept, one-hot or zero
- req_opcode  input  NUM_REQ x opcode_t  per-requester opcode
- req_op_a, req_op_b  input  NUM_REQ x 8  per-requester operands
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response accept
- rsp_id  output  ID_W  index of the requester that owns the response
- rsp_data  output  8  captured ALU result
- alu_load_en  output  1  to ALU load_en
- alu_opcode  output  opcode_t  to ALU opcode
- alu_op_a, alu_op_b  output  8  to ALU operands
- alu_result  input  8  from ALU alu_out
- busy  output  1  high in any state other than IDLE
- op_count  output  16  completed-operation counter

## Operation

- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, the arbiter picks a winner g.
  - req_ready[g]=1, combinational; all other req_ready bits are 0.
  - On the edge, latch opcode/op_a/op_b/g and go to ISSUE.
  - With no valid request, stay in IDLE.
- ISSUE: alu_load_en=1 with the latched fields on alu_*. Go to WAIT.
- WAIT: alu_result is valid. Register it into rsp_data, rsp_id=g. Go to RESP.
- RESP:
  - rsp_valid=1, and rsp_id/rsp_data are held stable.
  - On rsp_valid&&rsp_ready: op_count+1 (wraps 16'hFFFF→0), go to IDLE.
  - If rsp_ready is low, stay in RESP indefinitely.
- Round-robin arbitration:
  - Pointer ptr resets to 0.
  - The winner is the first index with req_valid set, searching ptr, ptr+1, … mod NUM_REQ.
  - After a grant to g, ptr←(g+1) mod NUM_REQ, wrapping at NUM_REQ-1→0.
  - ptr changes only on a grant.
- req_ready is 0 in ISSUE, WAIT and RESP. Requests are never accepted while an operation is in flight.
- Requesters must hold req_valid and fields stable until req_ready. Dropping req_valid before grant is allowed and simply removes the request.
- alu_load_en is high in exactly one cycle per accepted request.
- Reset values: state=IDLE, ptr=0, req_ready=0 (forced 0 while reset low), alu_load_en=0, alu_opcode=0, alu_op_a/b=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, op_count=0.
- Reset mid-operation (any state): in-flight operation discarded, no response is produced, op_count unchanged from its reset value 0.

## Timing

- Cycle 0: accept edge (req_valid&&req_ready).
- Cycle 1: ISSUE, alu_load_en=1; the ALU registers the result at the end of the cycle.
- Cycle 2: WAIT, rsp_data captured at the end of the cycle.
- Cycle 3: rsp_valid=1, the earliest response.
- Minimum request-to-request spacing is 4 cycles (IDLE, ISSUE, WAIT, RESP with rsp_ready=1).
- rsp_ready high in the first RESP cycle returns to IDLE. A new grant can then happen in the next cycle.
- All outputs are registered, except req_ready (a combinational function of state, ptr and req_valid).

## Structure

- Shared package alu_opcodes_pkg:
  - gains sched_state_t (IDLE, ISSUE, WAIT, RESP);
  - also holds a sched_req_t struct {opcode_t opc; operand_logic_t op_a, op_b;};
  - existing opcode_t and operand_logic_t are reused unchanged.
- Sub-module rr_arbiter #(NUM_REQ):
  - inputs: req vector, enable, clk/reset;
  - outputs: one-hot grant and grant index;
  - owns ptr and updates it on enable&&|req.
- Top level holds the FSM, operand latch, response register and op_count.
- Bench integrates the scheduler with the existing ALU for end-to-end checks.

## Test plan

- Single request: req0 A_PLUS_B a=8'h0F b=8'h01 -> alu_load_en once at cycle 1; rsp_valid at cycle 3 with rsp_id=0, rsp_data=8'h10; op_count=1.
- All four requesters valid continuously from reset, each with INCREMENT_A a=8'h0i -> grants in order 0,1,2,3,0; rsp_data 8'h01,8'h02,8'h03,8'h04.
- Back-pressure: req2 A_ROTATED_B a=8'h81 b=8'h01, rsp_ready low for 5 cycles -> rsp_valid/rsp_id=2/rsp_data=8'hC0 held stable for 5 cycles; req_ready stays 0 and no second alu_load_en occurs.
- Pointer wrap: after a grant to 3, requesters 0 and 3 both valid -> 0 wins. Then 3 wins, ptr becomes 0.
- Reset asserted in WAIT -> all outputs go to reset values immediately; no rsp_valid afterward; next request is serviced normally starting from ptr=0.
- op_count wrap: force 65536 completions (or preload via backdoor to 16'hFFFF) -> the next completion yields op_count=0.

Source files
------------

// File: rtl/alu_opcodes_pkg.sv
// Shared ALU definitions: opcodes, operand type, and the scheduler's
// state and request types.
package alu_opcodes_pkg;

    typedef enum logic [2:0] {
        A_PLUS_B    = 3'd0,
        A_MINUS_B   = 3'd1,
        A_AND_B     = 3'd2,
        A_OR_B      = 3'd3,
        A_XOR_B     = 3'd4,
        INCREMENT_A = 3'd5,
        A_ROTATED_B = 3'd6,
        A_SHIFTED_B = 3'd7
    } opcode_t;

    typedef logic [7:0] operand_logic_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

    typedef struct packed {
        opcode_t        opc;
        operand_logic_t op_a;
        operand_logic_t op_b;
    } sched_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at ptr. The pointer moves one
// past the winner whenever a grant is taken (enable with any request).
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;

    // First requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        logic            found;
        logic [ID_W:0]   sum;
        logic [ID_W-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr_q} + (ID_W+1)'(i);
            if (sum >= (ID_W+1)'(NUM_REQ)) begin
                sum = sum - (ID_W+1)'(NUM_REQ);
            end
            idx = sum[ID_W-1:0];
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    // The pointer advances only on an actual grant.
    always_comb begin
        ptr_d = ptr_q;
        if (enable && |req) begin
            ptr_d = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one registered ALU among NUM_REQ requesters. Operations are
// accepted one at a time in round-robin order. Each one is issued for
// a single cycle. The result is captured and then returned on a tagged
// response port that honours back-pressure.
module alu_rr_scheduler
    import alu_opcodes_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  opcode_t [NUM_REQ-1:0]    req_opcode,
    input  logic [NUM_REQ-1:0][7:0]  req_op_a,
    input  logic [NUM_REQ-1:0][7:0]  req_op_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [7:0]               rsp_data,
    output logic                     alu_load_en,
    output opcode_t                  alu_opcode,
    output logic [7:0]               alu_op_a,
    output logic [7:0]               alu_op_b,
    input  logic [7:0]               alu_result,
    output logic                     busy,
    output logic [15:0]              op_count
);

    sched_state_t       state_q;
    sched_state_t       state_d;
    sched_req_t         req_q;
    logic [ID_W-1:0]    id_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic [7:0]         rsp_data_q;
    logic               rsp_valid_q;
    logic               alu_load_en_q;
    logic               busy_q;
    logic [15:0]        op_count_q;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               arb_en;
    logic               accept;

    assign arb_en = (state_q == IDLE);
    assign accept = arb_en && (|req_valid);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (req_valid),
        .enable    (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Grants are only offered in IDLE and are suppressed while reset is held.
    assign req_ready = (reset && arb_en) ? grant : '0;

    // Next-state logic: a fixed four-step walk, stalling in RESP on back-pressure.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (|req_valid) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: latch the request, capture the result, count completions.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q         <= '0;
            id_q          <= '0;
            rsp_id_q      <= '0;
            rsp_data_q    <= '0;
            rsp_valid_q   <= 1'b0;
            alu_load_en_q <= 1'b0;
            busy_q        <= 1'b0;
            op_count_q    <= '0;
        end else begin
            alu_load_en_q <= (state_d == ISSUE);
            busy_q        <= (state_d != IDLE);
            rsp_valid_q   <= (state_d == RESP);
            if (accept) begin
                req_q.opc  <= req_opcode[grant_idx];
                req_q.op_a <= req_op_a[grant_idx];
                req_q.op_b <= req_op_b[grant_idx];
                id_q       <= grant_idx;
            end
            if (state_q == WAIT) begin
                rsp_data_q <= alu_result;
                rsp_id_q   <= id_q;
            end
            if (state_q == RESP && rsp_ready) begin
                op_count_q <= op_count_q + 16'd1;
            end
        end
    end

    assign alu_load_en = alu_load_en_q;
    assign alu_opcode  = req_q.opc;
    assign alu_op_a    = req_q.op_a;
    assign alu_op_b    = req_q.op_b;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_data    = rsp_data_q;
    assign busy        = busy_q;
    assign op_count    = op_count_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler. A small registered ALU sits behind
// the scheduler so that results are checked end to end.
module tb_alu_rr_scheduler;
    import alu_opcodes_pkg::*;

    logic             clk;
    logic             reset;
    logic [3:0]       req_valid;
    logic [3:0]       req_ready;
    opcode_t [3:0]    req_opcode;
    logic [3:0][7:0]  req_op_a;
    logic [3:0][7:0]  req_op_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_id;
    logic [7:0]       rsp_data;
    logic             alu_load_en;
    opcode_t          alu_opcode;
    logic [7:0]       alu_op_a;
    logic [7:0]       alu_op_b;
    logic [7:0]       alu_result;
    logic             busy;
    logic [15:0]      op_count;

    int errors = 0;
    int checks = 0;
    int load_cnt = 0;

    alu_rr_scheduler #(.NUM_REQ(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_opcode  (req_opcode),
        .req_op_a    (req_op_a),
        .req_op_b    (req_op_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .alu_load_en (alu_load_en),
        .alu_opcode  (alu_opcode),
        .alu_op_a    (alu_op_a),
        .alu_op_b    (alu_op_b),
        .alu_result  (alu_result),
        .busy        (busy),
        .op_count    (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu_calc(opcode_t op, logic [7:0] a, logic [7:0] b);
        logic [15:0] dbl;
        dbl = {a, a} >> b[2:0];
        case (op)
            A_PLUS_B:    return a + b;
            A_MINUS_B:   return a - b;
            A_AND_B:     return a & b;
            A_OR_B:      return a | b;
            A_XOR_B:     return a ^ b;
            INCREMENT_A: return a + 8'd1;
            A_ROTATED_B: return dbl[7:0];
            default:     return a << b[2:0];
        endcase
    endfunction

    // Registered ALU: result appears the cycle after load_en.
    always_ff @(posedge clk) begin
        if (alu_load_en) alu_result <= alu_calc(alu_opcode, alu_op_a, alu_op_b);
    end

    // Count ALU loads so that duplicate issues can be detected.
    always_ff @(posedge clk) begin
        if (alu_load_en === 1'b1) load_cnt <= load_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        for (int i = 0; i < 4; i++) begin
            req_opcode[i] = A_PLUS_B;
            req_op_a[i] = 8'h00;
            req_op_b[i] = 8'h00;
        end
        @(negedge clk);
        @(negedge clk);
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        checks++; if (alu_load_en !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_ctrl: load=%b rsp_valid=%b busy=%b expected 0 0 0", alu_load_en, rsp_valid, busy); end
        checks++; if (op_count !== 16'h0 || rsp_data !== 8'h00 || rsp_id !== 2'd0) begin errors++; $display("FAIL reset_data: op_count=%h rsp_data=%h rsp_id=%0d expected 0 0 0", op_count, rsp_data, rsp_id); end
        checks++; if (alu_op_a !== 8'h00 || alu_op_b !== 8'h00 || alu_opcode !== A_PLUS_B) begin errors++; $display("FAIL reset_alu: a=%h b=%h opc=%0d expected 0 0 0", alu_op_a, alu_op_b, alu_opcode); end
        req_valid = 4'h0;
        reset = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_single();
        req_opcode[0] = A_PLUS_B;
        req_op_a[0] = 8'h0F;
        req_op_b[0] = 8'h01;
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b expected 0001", req_ready); end
        tick();
        req_valid = 4'b0000;
        checks++; if (alu_load_en !== 1'b1 || alu_op_a !== 8'h0F || busy !== 1'b1) begin errors++; $display("FAIL single_issue: load=%b a=%h busy=%b expected 1 0f 1", alu_load_en, alu_op_a, busy); end
        tick();
        checks++; if (alu_load_en !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL single_wait: load=%b rsp_valid=%b expected 0 0", alu_load_en, rsp_valid); end
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 8'h10) begin errors++; $display("FAIL single_resp: valid=%b id=%0d data=%h expected 1 0 10", rsp_valid, rsp_id, rsp_data); end
        tick();
        checks++; if (rsp_valid !== 1'b0 || op_count !== 16'd1 || busy !== 1'b0) begin errors++; $display("FAIL single_done: valid=%b op_count=%0d busy=%b expected 0 1 0", rsp_valid, op_count, busy); end
        $display("test_single done: rsp_data=%h op_count=%0d", rsp_data, op_count);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            req_opcode[i] = INCREMENT_A;
            req_op_a[i] = 8'(i);
            req_op_b[i] = 8'h00;
        end
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        pulse_reset();
        for (int k = 0; k < 5; k++) begin
            int exp_id;
            exp_id = k % 4;
            #1;
            checks++; if (req_ready !== 4'(1 << exp_id)) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", k, req_ready, 4'(1 << exp_id)); end
            tick();
            tick();
            tick();
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_id) || rsp_data !== 8'(exp_id + 1)) begin errors++; $display("FAIL rr_resp%0d: valid=%b id=%0d data=%h expected 1 %0d %h", k, rsp_valid, rsp_id, rsp_data, exp_id, 8'(exp_id + 1)); end
            $display("rr txn %0d: id=%0d data=%h", k, rsp_id, rsp_data);
            tick();
        end
        req_valid = 4'h0;
        checks++; if (op_count !== 16'd5) begin errors++; $display("FAIL rr_count: got %0d expected 5", op_count); end
    endtask

    task automatic test_backpressure();
        int start_loads;
        start_loads = load_cnt;
        req_opcode[2] = A_ROTATED_B;
        req_op_a[2] = 8'h81;
        req_op_b[2] = 8'h01;
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        tick();
        tick();
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 8'hC0) begin errors++; $display("FAIL bp_hold%0d: valid=%b id=%0d data=%h expected 1 2 c0", c, rsp_valid, rsp_id, rsp_data); end
            checks++; if (req_ready !== 4'b0000 || alu_load_en !== 1'b0) begin errors++; $display("FAIL bp_quiet%0d: ready=%b load=%b expected 0000 0", c, req_ready, alu_load_en); end
        end
        req_valid = 4'h0;
        rsp_ready = 1'b1;
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release: rsp_valid=%b expected 0", rsp_valid); end
        checks++; if (load_cnt - start_loads !== 1) begin errors++; $display("FAIL bp_loads: got %0d expected 1", load_cnt - start_loads); end
        $display("test_backpressure done: data=%h", rsp_data);
    endtask

    task automatic test_ptr_wrap();
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            req_opcode[i] = A_PLUS_B;
            req_op_a[i] = 8'(i);
            req_op_b[i] = 8'(i);
        end
        req_valid = 4'b1000;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_first: got %b expected 1000", req_ready); end
        tick();
        req_valid = 4'b0000;
        tick();
        tick();
        checks++; if (rsp_id !== 2'd3 || rsp_data !== 8'h06) begin errors++; $display("FAIL wrap_resp3: id=%0d data=%h expected 3 06", rsp_id, rsp_data); end
        tick();
        req_valid = 4'b1001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_zero_wins: got %b expected 0001", req_ready); end
        tick();
        req_valid = 4'b1000;
        tick();
        tick();
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL wrap_resp0: id=%0d expected 0", rsp_id); end
        tick();
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_three_wins: got %b expected 1000", req_ready); end
        tick();
        req_valid = 4'b1001;
        tick();
        tick();
        tick();
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_ptr_zero: got %b expected 0001", req_ready); end
        req_valid = 4'b0000;
        $display("test_ptr_wrap done");
    endtask

    task automatic test_reset_mid();
        req_opcode[1] = A_XOR_B;
        req_op_a[1] = 8'hF0;
        req_op_b[1] = 8'h0F;
        req_opcode[3] = A_MINUS_B;
        req_op_a[3] = 8'h10;
        req_op_b[3] = 8'h01;
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0000;
        tick();
        reset = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || alu_load_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset_ctrl: valid=%b load=%b busy=%b expected 0 0 0", rsp_valid, alu_load_en, busy); end
        checks++; if (op_count !== 16'd0 || rsp_data !== 8'h00 || alu_op_a !== 8'h00) begin errors++; $display("FAIL mid_reset_data: op_count=%0d data=%h a=%h expected 0 00 00", op_count, rsp_data, alu_op_a); end
        tick();
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_no_rsp%0d: rsp_valid=%b expected 0", c, rsp_valid); end
        end
        req_valid = 4'b1010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_ptr_reset: got %b expected 0010", req_ready); end
        tick();
        req_valid = 4'b0000;
        tick();
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 8'hFF) begin errors++; $display("FAIL mid_after: valid=%b id=%0d data=%h expected 1 1 ff", rsp_valid, rsp_id, rsp_data); end
        tick();
        $display("test_reset_mid done: op_count=%0d", op_count);
    endtask

    task automatic test_count_wrap();
        dut.op_count_q = 16'hFFFF;
        req_opcode[0] = A_AND_B;
        req_op_a[0] = 8'h3C;
        req_op_b[0] = 8'h0F;
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        tick();
        tick();
        checks++; if (rsp_data !== 8'h0C) begin errors++; $display("FAIL wrap_cnt_data: got %h expected 0c", rsp_data); end
        tick();
        checks++; if (op_count !== 16'h0000) begin errors++; $display("FAIL wrap_cnt: got %h expected 0000", op_count); end
        $display("test_count_wrap done: op_count=%h", op_count);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        @(negedge clk);
        test_single();
        test_back_to_back();
        test_backpressure();
        test_ptr_wrap();
        test_reset_mid();
        test_count_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
